// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: execution controller for the single-cycle CPU board build.
// Turns debounced front-panel buttons/switches into a CPU clock-enable
// pulse (single-step or free-run at a switch-selected rate), a timed CPU
// reset, and a retired-step counter for the display.
// Optional breakpoint stop in RUN: define CPU_RUN_BRK_EN (adds pc, brk_addr).
module cpu_run_ctrl #(
   parameter int RUN_DIV    = 1000000,
   parameter int RST_CYCLES = 16,
   parameter int CW         = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    btn_db,
   input  logic [7:0]    sw_db,
`ifdef CPU_RUN_BRK_EN
   input  logic [31:0]   pc,
   input  logic [31:0]   brk_addr,
`endif
   output logic          cpu_ce,
   output logic          cpu_rst,
   output logic          running,
   output logic [1:0]    state,
   output logic [CW-1:0] instr_cnt
);

   // Prescaler must hold values up to RUN_DIV-1; reset counter up to RST_CYCLES-1.
   localparam int PW = $clog2(RUN_DIV + 1);
   localparam int RW = $clog2(RST_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      RUN  = 2'd2,
      CRST = 2'd3
   } state_t;

   state_t        st, st_n;
   logic [3:0]    btn_q;
   logic [3:0]    rise;
   logic [PW-1:0] presc, presc_n;
   logic [PW-1:0] tc_q, tc_n, tc_now;
   logic [RW-1:0] rcnt, rcnt_n;
   logic          ce_n;
   logic          brk_hit;
   logic [31:0]   tc_full;
   logic          unused_sw;

   assign unused_sw = ^sw_db[7:2];
   assign rise      = btn_db & ~btn_q;
   assign state     = st;

   // Run period for the current speed switch, floored at one cycle.
   always_comb begin
      tc_full = 32'(RUN_DIV) >> {sw_db[1:0], 1'b0};
      if (tc_full == 32'd0)
         tc_full = 32'd1;
      tc_now = tc_full[PW-1:0];
   end

`ifdef CPU_RUN_BRK_EN
   logic ce_q;

   // Remember last cycle's pulse so the PC compare sees the CPU's updated PC.
   always_ff @(posedge clk) begin
      if (rst) ce_q <= 1'b0;
      else     ce_q <= cpu_ce;
   end

   assign brk_hit = ce_q && (pc == brk_addr) && (brk_addr != 32'hFFFF_FFFF);
`else
   assign brk_hit = 1'b0;
`endif

   // Next-state, prescaler and reset-timer logic; reset button dominates, then
   // breakpoint, then run/stop, then step.
   always_comb begin
      st_n    = st;
      ce_n    = 1'b0;
      presc_n = presc;
      tc_n    = tc_q;
      rcnt_n  = rcnt;
      case (st)
         IDLE: begin
            if (rise[2]) begin
               st_n   = CRST;
               rcnt_n = '0;
            end else if (rise[1]) begin
               st_n    = RUN;
               presc_n = '0;
               tc_n    = tc_now;
            end else if (rise[0]) begin
               st_n = STEP;
               ce_n = 1'b1;
            end
         end
         STEP: begin
            if (rise[2]) begin
               st_n   = CRST;
               rcnt_n = '0;
            end else begin
               st_n = IDLE;
            end
         end
         RUN: begin
            if (rise[2]) begin
               // Any pulse due this cycle is dropped.
               st_n    = CRST;
               rcnt_n  = '0;
               presc_n = '0;
            end else if (brk_hit || rise[1]) begin
               st_n    = IDLE;
               presc_n = '0;
            end else if (presc == tc_q - PW'(1)) begin
               // Wrap: pulse and pick up any new speed for the next period.
               ce_n    = 1'b1;
               presc_n = '0;
               tc_n    = tc_now;
            end else begin
               presc_n = presc + PW'(1);
            end
         end
         CRST: begin
            if (rcnt == RW'(RST_CYCLES - 1)) begin
               st_n   = IDLE;
               rcnt_n = '0;
            end else begin
               rcnt_n = rcnt + RW'(1);
            end
         end
         default: st_n = IDLE;
      endcase
   end

   // State, counters and registered outputs. A button held through reset
   // loads btn_q so it produces no edge afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         st      <= IDLE;
         btn_q   <= btn_db;
         presc   <= '0;
         tc_q    <= PW'(1);
         rcnt    <= '0;
         cpu_ce  <= 1'b0;
         cpu_rst <= 1'b0;
         running <= 1'b0;
      end else begin
         st      <= st_n;
         btn_q   <= btn_db;
         presc   <= presc_n;
         tc_q    <= tc_n;
         rcnt    <= rcnt_n;
         cpu_ce  <= ce_n;
         cpu_rst <= (st_n == CRST);
         running <= (st_n == RUN);
      end
   end

   // Retired-step counter; clear button beats a coincident pulse, and the
   // count is held at zero while the CPU is being reset.
   always_ff @(posedge clk) begin
      if (rst)
         instr_cnt <= '0;
      else if (rise[3] || st_n == CRST || st == CRST)
         instr_cnt <= '0;
      else if (ce_n)
         instr_cnt <= instr_cnt + CW'(1);
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: cycle-level behavioural model plus directed checks.
// Build with CPU_RUN_BRK_EN defined to also exercise the breakpoint stop.
module tb_cpu_run_ctrl;
   localparam int RUN_DIV = 16;
   localparam int RSTC    = 16;

   logic        clk = 0;
   logic        rst = 1;
   logic [3:0]  btn_db = 4'b0001;
   logic [7:0]  sw_db = 8'h00;
   logic        cpu_ce, cpu_rst, running;
   logic [1:0]  state;
   logic [15:0] instr_cnt;
`ifdef CPU_RUN_BRK_EN
   logic [31:0] pc = 0;
   logic [31:0] brk_addr = 32'hFFFF_FFFF;
   logic        pc_clr = 0;
`endif

   cpu_run_ctrl #(.RUN_DIV(RUN_DIV), .RST_CYCLES(RSTC), .CW(16)) dut (
      .clk(clk), .rst(rst), .btn_db(btn_db), .sw_db(sw_db),
`ifdef CPU_RUN_BRK_EN
      .pc(pc), .brk_addr(brk_addr),
`endif
      .cpu_ce(cpu_ce), .cpu_rst(cpu_rst), .running(running),
      .state(state), .instr_cnt(instr_cnt));

   always #5 clk = ~clk;

`ifdef CPU_RUN_BRK_EN
   // Toy CPU: PC advances by 4 on every enabled cycle.
   always @(posedge clk) begin
      if (pc_clr)      pc <= 0;
      else if (cpu_ce) pc <= pc + 4;
   end
`endif

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(string nm, longint act, longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   function automatic int tc_of(logic [1:0] s);
      int t;
      t = RUN_DIV >> (2 * s);
      return (t < 1) ? 1 : t;
   endfunction

   // Behavioural model: mode 0 idle, 1 step, 2 run, 3 cpu reset.
   int         cyc = 0;
   int         m_mode = 0, m_due = 0, m_left = 0, m_cnt = 0;
   bit         m_ce = 0, m_ce_before = 0;
   logic [3:0] m_prev = 0;

   always @(posedge clk) begin
      logic [3:0] r;
      bit hit;
      cyc++;
      if (rst) begin
         m_mode = 0; m_ce = 0; m_ce_before = 0; m_cnt = 0; m_prev = btn_db;
      end else begin
         r = btn_db & ~m_prev;
         m_prev = btn_db;
         hit = 0;
`ifdef CPU_RUN_BRK_EN
         hit = m_ce_before && (pc == brk_addr) && (brk_addr != 32'hFFFF_FFFF);
`endif
         m_ce_before = m_ce;
         m_ce = 0;
         case (m_mode)
            0: if (r[2]) begin m_mode = 3; m_left = RSTC; end
               else if (r[1]) begin m_mode = 2; m_due = tc_of(sw_db[1:0]); end
               else if (r[0]) begin m_mode = 1; m_ce = 1; end
            1: if (r[2]) begin m_mode = 3; m_left = RSTC; end
               else m_mode = 0;
            2: if (r[2]) begin m_mode = 3; m_left = RSTC; end
               else if (hit || r[1]) m_mode = 0;
               else begin
                  m_due--;
                  if (m_due == 0) begin m_ce = 1; m_due = tc_of(sw_db[1:0]); end
               end
            default: begin m_left--; if (m_left == 0) m_mode = 0; end
         endcase
         if (m_ce) m_cnt = (m_cnt + 1) % 65536;
         if (r[3] || m_mode == 3) m_cnt = 0;
      end
   end

   // Every-cycle comparison against the model, plus pulse bookkeeping.
   int npulse = 0, last_cyc = 0, last_gap = 0;
   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("cycle_outputs {ce,rst,run,state,cnt}",
             {cpu_ce, cpu_rst, running, state, instr_cnt},
             {m_ce, (m_mode == 3), (m_mode == 2), 2'(m_mode), 16'(m_cnt)});
         if (cpu_ce && cpu_rst) chk("ce_and_rst_exclusive", 1, 0);
      end
      if (cpu_ce) begin
         npulse++;
         last_gap = cyc - last_cyc;
         last_cyc = cyc;
      end
   end

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle button press beginning at a negedge.
   task automatic press(logic [3:0] m);
      btn_db = m;
      @(negedge clk);
      btn_db = 0;
   endtask

   initial begin
      int p0, c0, rc;
      // Power-on with step held through reset: no edge may appear.
      tick(3);
      rst = 0;
      tick(5);
      chk("held_thru_reset_pulses", npulse, 0);
      chk("held_thru_reset_state", state, 0);
      chk("held_thru_reset_cnt", instr_cnt, 0);
      btn_db = 0;
      tick(3);

      // Three single steps, 50 cycles apart, each 1 cycle after its rise.
      for (int i = 0; i < 3; i++) begin
         btn_db = 4'b0001;
         @(negedge clk);
         chk("step_latency_ce", cpu_ce, 1);
         tick(3);
         btn_db = 0;
         tick(46);
      end
      chk("step_cnt", instr_cnt, 3);
      chk("step_pulses", npulse, 3);

      // Free run at sw=00: pulses at entry+16k, six in 100 cycles.
      p0 = npulse;
      press(4'b0010);
      tick(99);
      chk("run_pulses_100", npulse - p0, 6);
      chk("run_cnt", instr_cnt, 9);
      chk("run_running", running, 1);
      sw_db = 8'h01;
      tick(40);
      chk("run_gap_sw01", last_gap, 4);
      press(4'b0010);
      chk("stop_running", running, 0);
      p0 = npulse;
      tick(40);
      chk("stop_no_pulses", npulse - p0, 0);

      // Fastest speed: TC floors at 1, a pulse every cycle.
      sw_db = 8'h03;
      press(4'b0010);
      c0 = instr_cnt;
      tick(10);
      chk("tc1_cnt_delta", instr_cnt - c0, 10);
      press(4'b0010);
      sw_db = 8'h01;
      tick(5);

      // CPU reset and run/stop together while running: reset wins.
      press(4'b0010);
      tick(20);
      btn_db = 4'b0110;
      @(negedge clk);
      btn_db = 0;
      chk("crst_state", state, 3);
      chk("crst_cnt", instr_cnt, 0);
      p0 = npulse;
      rc = cpu_rst ? 1 : 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (i == 3) btn_db = 4'b0001;
         if (i == 5) btn_db = 0;
         if (cpu_rst) rc++;
      end
      chk("crst_len", rc, 16);
      chk("crst_exit_state", state, 0);
      tick(10);
      chk("crst_step_discarded", npulse - p0, 0);

      // Clear and step rising together: clear wins over the increment.
      press(4'b0001);
      tick(5);
      chk("pre_clear_cnt", instr_cnt, 1);
      btn_db = 4'b1001;
      @(negedge clk);
      chk("clear_step_ce", cpu_ce, 1);
      chk("clear_step_cnt", instr_cnt, 0);
      btn_db = 0;
      tick(5);
      chk("clear_step_cnt_after", instr_cnt, 0);

`ifdef CPU_RUN_BRK_EN
      // Breakpoint at 0xC stops after the third pulse.
      press(4'b1000);
      brk_addr = 32'h0000_000C;
      pc_clr = 1;
      tick(1);
      pc_clr = 0;
      press(4'b0010);
      tick(30);
      chk("brk_state", state, 0);
      chk("brk_cnt", instr_cnt, 3);
      // Disabled compare value: run never stops on its own.
      brk_addr = 32'hFFFF_FFFF;
      pc_clr = 1;
      tick(1);
      pc_clr = 0;
      press(4'b0010);
      tick(60);
      chk("brk_off_running", running, 1);
      press(4'b0010);
      tick(3);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Execution controller for the single-cycle CPU board build.
- Consumes debounced button and switch levels from the front-panel debouncer.
- Generates the CPU clock-enable pulse and the CPU synchronous reset.
- Supports single-step, free-run at a switch-selected rate, and a timed CPU reset; counts retired steps for the display.

Parameters:
- RUN_DIV, 1000000, base run period in clk cycles (sw[1:0]=00).
- RST_CYCLES, 16, number of cycles cpu_rst is held high.
- CW, 16, width of instr_cnt.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_db  in  4  debounced buttons: [0] step, [1] run/stop toggle, [2] CPU reset, [3] clear instr_cnt
- sw_db  in  8  debounced switches: [1:0] run speed select; [7:2] unused
- cpu_ce  out  1  one-cycle CPU clock-enable pulse
- cpu_rst  out  1  synchronous reset to the CPU
- running  out  1  high while in RUN
- state  out  2  IDLE=0, STEP=1, RUN=2, CRST=3
- instr_cnt  out  CW  count of cpu_ce pulses, wraps modulo 2^CW
- pc  in  32  CPU PC; present only with BRK_EN
- brk_addr  in  32  breakpoint address; present only with BRK_EN

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, cpu_ce=0, cpu_rst=0, running=0, instr_cnt=0, prescaler=0, btn_q<=btn_db.
  - Loading btn_q from btn_db means a button held through reset produces no edge.
- Edge detection: rise[i] = btn_db[i] & ~btn_q[i]; btn_q updates every cycle.
  - Only rising edges act; held levels never repeat.
- Priority of simultaneous rises, all evaluated in the same cycle: btn[2] > btn[1] > btn[0].
  - btn[3] is independent of this priority.
- btn[3] rise: instr_cnt<=0 in any state.
  - If a cpu_ce pulse occurs in the same cycle, the clear wins and instr_cnt=0.
- Run terminal count: TC = RUN_DIV >> (2*sw_db[1:0]).
  - If TC evaluates below 1, TC=1.
  - TC is sampled every cycle; a speed change takes effect on the next prescaler wrap.
- IDLE:
  - btn[2] rise -> CRST.
  - btn[1] rise -> RUN, prescaler=0.
  - btn[0] rise -> STEP.
  - Otherwise hold.
- STEP: lasts exactly 1 cycle.
  - cpu_ce=1 during this cycle; instr_cnt+1.
  - Then IDLE, unless btn[2] rises in this cycle, which goes to CRST.
  - Latency from the btn_db[0] rising edge (as seen at posedge) to cpu_ce high: 1 cycle.
- RUN: running=1.
  - Prescaler counts 0..TC-1.
  - At TC-1: cpu_ce=1 for one cycle, instr_cnt+1, prescaler<=0.
  - First pulse occurs TC cycles after entry.
  - btn[1] rise -> IDLE, prescaler=0, no pulse in that cycle.
  - btn[0] ignored.
  - btn[2] rise -> CRST; a pulse due in that same cycle is suppressed.
- CRST:
  - cpu_rst=1, cpu_ce=0, instr_cnt<=0, and an internal counter runs for RST_CYCLES cycles, then IDLE.
  - btn[0], btn[1] and btn[2] rises are discarded, not queued.
- cpu_ce is only ever high in STEP, or in RUN at the prescaler wrap.
- cpu_ce and cpu_rst are never high together.
- All outputs are registered.

Optional Feature:
- Macro: CPU_RUN_BRK_EN.
- Defined:
  - Adds the pc and brk_addr ports.
  - In RUN, if pc==brk_addr in the cycle after a cpu_ce pulse, state->IDLE and running=0.
  - The compare is ignored when brk_addr==32'hFFFF_FFFF.
  - Breakpoint has lower priority than a btn[2] rise and higher priority than a btn[1] rise.
- Undefined: no pc or brk_addr ports; RUN exits only via btn[1] or btn[2].

Test Plan:
- Power-on with rst=1 for 3 cycles and btn_db=4'b0001 held through reset -> release rst, keep btn held: no cpu_ce, state=0, instr_cnt=0.
- IDLE, RUN_DIV=16: pulse btn_db[0] 3 times, each rise separated by 50 cycles -> exactly 3 one-cycle cpu_ce pulses, each 1 cycle after its rise; instr_cnt=3.
- RUN_DIV=16, sw=00: btn[1] rise, wait 100 cycles -> cpu_ce pulses at entry+16, +32, ..., 6 pulses in total; set sw=01 -> subsequent spacing 4; btn[1] rise -> no further pulses, running=0.
- In RUN: btn[2] and btn[1] rise in the same cycle -> CRST, cpu_rst high for 16 cycles, instr_cnt=0, then IDLE; a btn[0] rise during CRST yields no pulse afterwards.
- btn[3] rise coincident with a STEP pulse -> instr_cnt=0.
- With CPU_RUN_BRK_EN defined: brk_addr=32'h0000_000C, pc advancing by 4 per cpu_ce from 0 -> RUN stops after the 3rd pulse, state=IDLE, instr_cnt=3; with brk_addr=32'hFFFF_FFFF, RUN never stops on its own.
